// File: rtl/hist_eq_pkg.sv
// Shared constants and state encoding for the histogram-equalisation LUT builder.
package hist_eq_pkg;

  localparam int BINS           = 256;
  localparam int DEF_HIST_WIDTH = 16;
  localparam int CDF_W          = DEF_HIST_WIDTH + 8;
  localparam int NUM_W          = CDF_W + 9;

  localparam int SUM_CYCLES     = 257;
  localparam int BIN_CYCLES     = 11;
  localparam int TOTAL_LATENCY  = SUM_CYCLES + 1 + BINS * BIN_CYCLES + 1;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    CHECK,
    MAP_RD,
    MAP_WAIT,
    DIV,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/lut_divider.sv
// Eight-step restoring divider; the caller guarantees dividend < 256*divisor.
module lut_divider #(
  parameter int NUM_W = 33,
  parameter int DEN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             done,
  output logic [7:0]       quotient
);

  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] dsh;
  logic [2:0]       step;
  logic             run;
  logic             ge;

  assign ge   = rem >= dsh;
  assign done = run && (step == 3'd7);

  // divisor starts aligned to quotient bit 7 and walks down one bit per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      dsh      <= '0;
      step     <= '0;
      run      <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= dividend;
      dsh      <= NUM_W'(divisor) << 7;
      step     <= '0;
      run      <= 1'b1;
      quotient <= '0;
    end else if (run) begin
      if (ge) rem <= rem - dsh;
      quotient <= {quotient[6:0], ge};
      dsh      <= dsh >> 1;
      step     <= step + 3'd1;
      if (step == 3'd7) run <= 1'b0;
    end
  end

endmodule

// File: rtl/hist_eq_lut_builder.sv
// Reads a 256-bin histogram twice and writes a 256-entry equalisation LUT.
// Optional macro HIST_EQ_LUT_ROUND_EN: round-to-nearest instead of truncating division.
//
// state    | meaning
// IDLE     | wait for start, clear accumulators
// SUM      | stream all bins, accumulate total and first non-zero bin
// CHECK    | form denominator, detect flat frame
// MAP_RD   | address bin i
// MAP_WAIT | accumulate cdf, form numerator, kick divider
// DIV      | eight divider steps
// WRITE    | write LUT entry i
// DONE     | one-cycle completion pulse
module hist_eq_lut_builder
  import hist_eq_pkg::*;
#(
  parameter int HIST_WIDTH = 16,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [7:0]            hist_addr,
  input  logic [HIST_WIDTH-1:0] hist_data,
  output logic                  lut_we,
  output logic [7:0]            lut_addr,
  output logic [OUT_WIDTH-1:0]  lut_data,
  output logic                  busy,
  output logic                  done,
  output logic                  flat
);

  localparam int CW = HIST_WIDTH + 8;
  localparam int NW = CW + 9;
  localparam logic [NW-1:0] SCALE = NW'(255);

  state_t        state, state_nx;
  logic [8:0]    sum_cnt;
  logic [7:0]    bin_idx;
  logic [CW-1:0] total, cdf, cdf_min, denom, cdf_nx;
  logic [NW-1:0] num_nx;
  logic          div_start, div_done;
  logic [7:0]    quot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = SUM;
      SUM:      if (sum_cnt == 9'(SUM_CYCLES - 1)) state_nx = CHECK;
      CHECK:    state_nx = MAP_RD;
      MAP_RD:   state_nx = MAP_WAIT;
      MAP_WAIT: state_nx = DIV;
      DIV:      if (div_done) state_nx = WRITE;
      WRITE:    state_nx = (bin_idx == 8'(BINS - 1)) ? DONE : MAP_RD;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    cdf_nx = cdf + CW'(hist_data);
    num_nx = '0;
    if (cdf_nx >= cdf_min) num_nx = NW'(cdf_nx - cdf_min) * SCALE;
`ifdef HIST_EQ_LUT_ROUND_EN
    num_nx = num_nx + NW'(denom >> 1);
`endif
  end

  // sum_cnt 1..256 carries the data for bin sum_cnt-1 (one-cycle RAM latency)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_cnt <= '0;
      bin_idx <= '0;
      total   <= '0;
      cdf     <= '0;
      cdf_min <= '0;
      denom   <= '0;
      flat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sum_cnt <= '0;
          bin_idx <= '0;
          total   <= '0;
          cdf     <= '0;
          cdf_min <= '0;
          denom   <= '0;
          if (start) flat <= 1'b0;
        end
        SUM: begin
          sum_cnt <= sum_cnt + 9'd1;
          if (sum_cnt != 9'd0) begin
            total <= total + CW'(hist_data);
            if (cdf_min == '0 && hist_data != '0) cdf_min <= CW'(hist_data);
          end
        end
        CHECK: begin
          denom <= total - cdf_min;
          flat  <= (total == cdf_min);
        end
        MAP_WAIT: cdf <= cdf_nx;
        WRITE:    bin_idx <= bin_idx + 8'd1;
        default: ;
      endcase
    end
  end

  // a flat frame still runs the divider so every bin takes the same time
  assign div_start = (state == MAP_WAIT);

  lut_divider #(
    .NUM_W (NW),
    .DEN_W (CW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (flat ? '0 : num_nx),
    .divisor  (denom),
    .done     (div_done),
    .quotient (quot)
  );

  assign hist_addr = (state == SUM) ? sum_cnt[7:0] : bin_idx;
  assign lut_we    = (state == WRITE);
  assign lut_addr  = lut_we ? bin_idx : 8'd0;
  assign lut_data  = !lut_we ? '0 : (flat ? OUT_WIDTH'(bin_idx) : OUT_WIDTH'(quot));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: doc/hist_eq_lut_builder.md
# hist_eq_lut_builder

Consumer of the 256-bin histogram produced by the histogram calculator. On a start pulse it reads the histogram RAM twice: once to find the total pixel count and the first non-zero bin, then to build the cumulative distribution. It writes a 256×8 histogram-equalisation LUT into a downstream RAM that the pixel pipeline uses for remapping.

## Interface
- HIST_WIDTH, 16: width of one histogram bin
- OUT_WIDTH, 8: LUT entry width; bins fixed at 256
- clk in 1: single clock, all logic on rising edge
- rst in 1: reset, asynchronous, active-low
- start in 1: one-cycle request; connect to histogram out_valid
- hist_addr out 8: histogram RAM read address
- hist_data in HIST_WIDTH: histogram RAM read data, valid one cycle after hist_addr
- lut_we out 1: LUT RAM write enable
- lut_addr out 8: LUT write address
- lut_data out OUT_WIDTH: LUT write data
- busy out 1: high from the cycle after start is accepted until done
- done out 1: one-cycle pulse when the LUT is complete
- flat out 1: denominator was zero; identity LUT written; held until the next accepted start

## Operation
- States: IDLE, SUM, CHECK, MAP_RD, MAP_WAIT, DIV, WRITE, DONE.
- IDLE:
  - start=1 → SUM.
  - Clear total, cdf, cdf_min, bin index and flat.
- SUM:
  - Issue hist_addr 0..255 on consecutive cycles.
  - Accumulate each returned word into total (CDF_W = HIST_WIDTH+8 bits, cannot overflow).
  - cdf_min = first non-zero bin value.
  - Leave after the data for bin 255 is captured.
- CHECK:
  - denom = total − cdf_min.
  - denom==0 (single-valued or empty frame) → flat=1.
- MAP_RD: hist_addr = i.
- MAP_WAIT:
  - cdf += hist_data.
  - num = (cdf ≥ cdf_min) ? (cdf − cdf_min)×255 : 0.
  - num is CDF_W+9 bits, unsigned.
- DIV: 8-step restoring division num/denom.
  - Quotient is ≤255 by construction, so 8 bits are sufficient.
  - Skipped when flat=1; result = i.
- WRITE: lut_we=1, lut_addr=i, lut_data=quotient (or i if flat).
  - i==255 → DONE, otherwise i+1 → MAP_RD.
- DONE: done=1 for one cycle → IDLE.
- start is ignored in every state except IDLE, including DONE.
- The histogram RAM is not modified by this block.
- Reset mid-operation:
  - Immediate return to IDLE; all registers are cleared.
  - LUT contents are undefined until a full run completes.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1–257: SUM. hist_addr k is driven in cycle k+1; data is captured in cycle k+2.
- Cycle 258: CHECK.
- Per bin: 11 cycles (MAP_RD 1, MAP_WAIT 1, DIV 8, WRITE 1), also when flat (DIV cycles are idle).
- Cycles 259–3074: 256 bins.
- lut_we for bin i is asserted in cycle 269+11i.
- Cycle 3075: done=1, busy=1. Cycle 3076: busy=0, and start is accepted again.
- Reset values: hist_addr=0, lut_we=0, lut_addr=0, lut_data=0, busy=0, done=0, flat=0.
- lut_we is high for exactly one cycle per bin: 256 pulses per run.

## Configuration
- Macro HIST_EQ_LUT_ROUND_EN.
- Defined: num += denom>>1 before division, giving round-to-nearest. The quotient stays ≤255.
- Undefined: truncating division.
- Cycle counts are identical in both cases.

## Structure
- Package hist_eq_pkg:
  - BINS=256, CDF_W, NUM_W, state enum.
  - Cycle constants: SUM_CYCLES=257, BIN_CYCLES=11, TOTAL_LATENCY=3075.
- Sub-module lut_divider: 8-iteration restoring divider with start/done, NUM_W dividend, CDF_W divisor, 8-bit quotient.

## Test plan
- All bins = 4 (total 1024, cdf_min 4) → lut[i]=i for all i; flat=0; done at cycle 3075.
- Bin 10 = 100, bin 200 = 300, others 0 → lut[0..199]=0, lut[200..255]=255.
- Bin 77 = 5000 only → flat=1; lut[i]=i; 256 writes; same latency.
- Bins 0, 1, 2 = 1 each → lut[1]=127 without HIST_EQ_LUT_ROUND_EN, 128 with it; lut[2]=255.
- start re-pulsed at cycles 100 and 3075 → ignored; exactly one done; a start at cycle 3076 begins a new run.
- rst low at cycle 1000 → busy, lut_we and done are 0 immediately; a new start completes in 3075 cycles with a correct LUT.
